demux_tdm_2ch: RTL and testbench
================================

DEMUX_TDM_2CH -- requirements
Module: demux_tdm_2ch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the sample width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_data, input, WIDTH bits: the interleaved TDM sample stream (slot 0, slot 1, slot 0, ...).
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-006 The block SHALL have port in_sof, input, 1 bit: start of frame; qualified by in_valid; marks the slot-0 sample.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-008 The block SHALL have port ch0_data, output, WIDTH bits: the registered slot-0 sample of the last complete frame.
REQ-009 The block SHALL have port ch1_data, output, WIDTH bits: the registered slot-1 sample of the last complete frame.
REQ-010 The block SHALL have port out_valid, output, 1 bit: ch0_data and ch1_data hold an unconsumed frame.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream consumes the frame when out_valid=1.
REQ-012 The block SHALL have port sync_err, output, 1 bit: a one-cycle registered pulse on a framing violation.

Function
REQ-013 An input beat SHALL be accepted only when in_valid=1 and in_ready=1 in the same cycle; no other state change is caused by input.
REQ-014 The FSM SHALL have three states: HUNT (searching for sof), SLOT0 (expecting sof beat), and SLOT1 (expecting the second beat).
REQ-015 In HUNT, an accepted beat with in_sof=0 SHALL be discarded silently; with in_sof=1 its data SHALL be stored in the ch0 staging register and the FSM SHALL move to SLOT1.
REQ-016 In SLOT1, an accepted beat with in_sof=0 SHALL complete the frame: ch0 staging goes to ch0_data, in_data goes to ch1_data, out_valid=1 next cycle, and the FSM moves to SLOT0.
REQ-017 In SLOT1, an accepted beat with in_sof=1 SHALL pulse sync_err, abandon the partial frame, and load the beat into ch0 staging, with the FSM remaining in SLOT1.
REQ-018 In SLOT0, an accepted beat with in_sof=1 SHALL be stored in ch0 staging and the FSM SHALL move to SLOT1.
REQ-019 In SLOT0, an accepted beat with in_sof=0 SHALL pulse sync_err and drop the beat, and the FSM SHALL move to HUNT.
REQ-020 in_ready SHALL be combinational: 0 only when state=SLOT1, out_valid=1 and out_ready=0; 1 otherwise.
REQ-021 A frame transfer SHALL occur when out_valid=1 and out_ready=1; out_valid clears next cycle unless a new frame completes in the same cycle, in which case out_valid stays 1 with the new data.
REQ-022 While out_valid=1 and out_ready=0, ch0_data and ch1_data SHALL hold their values.
REQ-023 Latency SHALL be one cycle from slot-1 beat acceptance to out_valid=1; sustained throughput SHALL be one frame per two cycles with out_ready held at 1.
REQ-024 sync_err SHALL assert for exactly one cycle per violation and SHALL never assert in HUNT.

Reset
REQ-025 While rst_n=0, regardless of clk, the FSM SHALL be in HUNT, out_valid=0, sync_err=0, ch0_data=0, ch1_data=0, and ch0 staging=0; in_ready SHALL therefore be 1.
REQ-026 Reset asserted mid-frame SHALL discard any partial or unconsumed frame, and after release the block SHALL hunt for the next in_sof.

Verification
REQ-027 Back-to-back beats with WIDTH=8 and out_ready=1: (sof,0x11),(0x22),(sof,0x33),(0x44) -> out_valid on cycles 2 and 4 with ch0/ch1 = 0x11/0x22, then 0x33/0x44, and sync_err never asserting.
REQ-028 After reset, beats (0xAA),(0xBB),(sof,0x01),(0x02) -> 0xAA and 0xBB dropped, one frame 0x01/0x02, and no sync_err.
REQ-029 Beats (sof,0x10),(sof,0x20),(0x30) -> one sync_err pulse on the second beat, and a single frame 0x20/0x30 output.
REQ-030 Frame 0x01/0x02 completes, then beat (0x05) without sof -> sync_err pulse, FSM in HUNT, and the next (sof,0x06),(0x07) yields frame 0x06/0x07.
REQ-031 out_ready=0 while a frame is held, with a second frame's beats arriving: in_ready=0 at the second slot-1 beat and the first frame stable; raising out_ready -> first frame consumed, second accepted the same cycle, and out_valid stays 1.
REQ-032 rst_n pulled low asynchronously between slot 0 and slot 1 -> all outputs 0 immediately, and after release a lone (0x99) beat is dropped without sync_err.

Source files
------------

// File: rtl/demux_tdm_2ch.sv
// Two-slot TDM demultiplexer: splits an interleaved slot0/slot1 stream into
// paired channel samples behind a valid/ready output register.
module demux_tdm_2ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic [WIDTH-1:0] ch0_data,
  output logic [WIDTH-1:0] ch1_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sync_err
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SLOT0 = 2'd1,
    SLOT1 = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] stage0;
  logic             accept;
  logic             load_stage;
  logic             complete;
  logic             err_next;

  // Only a completing slot-1 beat can collide with an unconsumed frame.
  assign in_ready = !((state == SLOT1) && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next = state;
    load_stage = 1'b0;
    complete   = 1'b0;
    err_next   = 1'b0;
    if (accept) begin
      unique case (state)
        HUNT: begin
          if (in_sof) begin
            load_stage = 1'b1;
            state_next = SLOT1;
          end
        end
        SLOT0: begin
          if (in_sof) begin
            load_stage = 1'b1;
            state_next = SLOT1;
          end else begin
            err_next   = 1'b1;
            state_next = HUNT;
          end
        end
        SLOT1: begin
          if (in_sof) begin
            err_next   = 1'b1;
            load_stage = 1'b1;
          end else begin
            complete   = 1'b1;
            state_next = SLOT0;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      stage0    <= '0;
      ch0_data  <= '0;
      ch1_data  <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      state    <= state_next;
      sync_err <= err_next;
      if (load_stage) stage0 <= in_data;
      if (complete) begin
        ch0_data  <= stage0;
        ch1_data  <= in_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux_tdm_2ch.sv
// Directed bench for demux_tdm_2ch: vector table plus hand-written stall and
// asynchronous-reset sequences.
module tb_demux_tdm_2ch;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sof;
  logic       in_ready;
  logic [7:0] ch0_data;
  logic [7:0] ch1_data;
  logic       out_valid;
  logic       out_ready;
  logic       sync_err;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       rst;
    logic       v;
    logic       sof;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_c0;
    logic [7:0] e_c1;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  demux_tdm_2ch #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_ready (in_ready),
    .ch0_data (ch0_data),
    .ch1_data (ch1_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sync_err (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(int r, int v, int s, int d, int o,
                              int ir, int ov, int c0, int c1, int e);
    vec_t x;
    x.rst = (r != 0); x.v = (v != 0); x.sof = (s != 0); x.d = 8'(d);
    x.ordy = (o != 0); x.e_ir = (ir != 0); x.e_ov = (ov != 0);
    x.e_c0 = 8'(c0); x.e_c1 = 8'(c1); x.e_err = (e != 0);
    return x;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic check_outs(string tag, logic ov, logic [7:0] c0, logic [7:0] c1, logic e);
    check({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, " ch0_data"},  32'(ch0_data),  32'(c0));
    check({tag, " ch1_data"},  32'(ch1_data),  32'(c1));
    check({tag, " sync_err"},  32'(sync_err),  32'(e));
  endtask

  // Entered and left at posedge+1: in_ready is checked before the edge,
  // registered outputs just after it.
  task automatic step(string tag, vec_t x);
    in_valid  = x.v;
    in_sof    = x.sof;
    in_data   = x.d;
    out_ready = x.ordy;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'(x.e_ir));
    @(posedge clk);
    #1;
    check_outs(tag, x.e_ov, x.e_c0, x.e_c1, x.e_err);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check_outs("reset", 1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b1;

    //            rst v sof  data rdy  ir ov  c0    c1   err
    tbl.push_back(mk(1, 1, 1, 'h11, 1,  1, 0, 'h00, 'h00, 0));
    tbl.push_back(mk(0, 1, 0, 'h22, 1,  1, 1, 'h11, 'h22, 0));
    tbl.push_back(mk(0, 1, 1, 'h33, 1,  1, 0, 'h11, 'h22, 0));
    tbl.push_back(mk(0, 1, 0, 'h44, 1,  1, 1, 'h33, 'h44, 0));
    tbl.push_back(mk(0, 0, 0, 'h00, 1,  1, 0, 'h33, 'h44, 0));
    tbl.push_back(mk(1, 1, 0, 'hAA, 1,  1, 0, 'h00, 'h00, 0));
    tbl.push_back(mk(0, 1, 0, 'hBB, 1,  1, 0, 'h00, 'h00, 0));
    tbl.push_back(mk(0, 1, 1, 'h01, 1,  1, 0, 'h00, 'h00, 0));
    tbl.push_back(mk(0, 1, 0, 'h02, 1,  1, 1, 'h01, 'h02, 0));
    tbl.push_back(mk(0, 1, 0, 'h05, 1,  1, 0, 'h01, 'h02, 1));
    tbl.push_back(mk(0, 1, 1, 'h06, 1,  1, 0, 'h01, 'h02, 0));
    tbl.push_back(mk(0, 1, 0, 'h07, 1,  1, 1, 'h06, 'h07, 0));
    tbl.push_back(mk(0, 0, 0, 'h00, 1,  1, 0, 'h06, 'h07, 0));
    tbl.push_back(mk(0, 1, 1, 'h10, 1,  1, 0, 'h06, 'h07, 0));
    tbl.push_back(mk(0, 1, 1, 'h20, 1,  1, 0, 'h06, 'h07, 1));
    tbl.push_back(mk(0, 1, 0, 'h30, 1,  1, 1, 'h20, 'h30, 0));
    tbl.push_back(mk(0, 0, 0, 'h00, 1,  1, 0, 'h20, 'h30, 0));
    tbl.push_back(mk(0, 0, 1, 'h55, 1,  1, 0, 'h20, 'h30, 0));
    tbl.push_back(mk(0, 1, 0, 'h66, 1,  1, 0, 'h20, 'h30, 1));
    tbl.push_back(mk(0, 0, 0, 'h00, 1,  1, 0, 'h20, 'h30, 0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // Held frame back-pressures the next slot-1 beat until out_ready rises.
    do_reset();
    step("bp0", mk(0, 1, 1, 'hA1, 0,  1, 0, 'h00, 'h00, 0));
    step("bp1", mk(0, 1, 0, 'hA2, 0,  1, 1, 'hA1, 'hA2, 0));
    step("bp2", mk(0, 1, 1, 'hB1, 0,  1, 1, 'hA1, 'hA2, 0));
    step("bp3", mk(0, 1, 0, 'hB2, 0,  0, 1, 'hA1, 'hA2, 0));
    step("bp4", mk(0, 1, 0, 'hB2, 0,  0, 1, 'hA1, 'hA2, 0));
    step("bp5", mk(0, 1, 0, 'hB2, 1,  1, 1, 'hB1, 'hB2, 0));
    step("bp6", mk(0, 0, 0, 'h00, 1,  1, 0, 'hB1, 'hB2, 0));

    // Asynchronous reset between slot 0 and slot 1 with a frame still held.
    do_reset();
    step("ar0", mk(0, 1, 1, 'h31, 0,  1, 0, 'h00, 'h00, 0));
    step("ar1", mk(0, 1, 0, 'h32, 0,  1, 1, 'h31, 'h32, 0));
    step("ar2", mk(0, 1, 1, 'h77, 0,  1, 1, 'h31, 'h32, 0));
    in_valid = 1'b0; in_sof = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async in_ready", 32'(in_ready), 32'd1);
    check_outs("async", 1'b0, 8'h00, 8'h00, 1'b0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("ar3", mk(0, 1, 0, 'h99, 1,  1, 0, 'h00, 'h00, 0));
    step("ar4", mk(0, 1, 0, 'h55, 1,  1, 0, 'h00, 'h00, 0));
    step("ar5", mk(0, 1, 1, 'h12, 1,  1, 0, 'h00, 'h00, 0));
    step("ar6", mk(0, 1, 0, 'h34, 1,  1, 1, 'h12, 'h34, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
